// File: rtl/spi_pixel_loader_pkg.sv
// Shared types and constants for the SPI pixel loader.
package spi_pixel_loader_pkg;

  localparam int NUM_PIXEL_BYTES = 72;
  localparam int BYTE_W          = 8;
  localparam int COUNT_W         = 7;
  localparam int STATE_W         = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  // MSB-first assembly: each new bit enters at the LSB end.
  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] cur,
                                                 input logic              bit_in);
    return {cur[BYTE_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_pixel_loader_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with a registered rising-edge pulse.
// STAGES must be at least 2; RST_VAL is the idle level of the input.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // rise is registered so the pulse is glitch-free and exactly one clk wide.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/spi_pixel_loader.sv
// SPI mode-0 slave that assembles bytes and strobes them into a pixel frame buffer.
// Optional SPI_PIXEL_LOADER_CHECKSUM_EN adds a running XOR checksum output.
module spi_pixel_loader
  import spi_pixel_loader_pkg::*;
#(
  parameter int NUM_BYTES   = NUM_PIXEL_BYTES,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               sclk,
  input  logic               mosi,
  input  logic               ss_n,
  input  logic               network_calc,
  input  logic               frame_clr,
  output logic [BYTE_W-1:0]  spi_in,
  output logic               shift_SPI,
  output logic               write_en,
  output logic [COUNT_W-1:0] byte_count,
  output logic               image_ready,
  output logic               overrun,
`ifdef SPI_PIXEL_LOADER_CHECKSUM_EN
  output logic [BYTE_W-1:0]  checksum,
`endif
  output logic [STATE_W-1:0] state_dbg
);

  // Handshake: shift_SPI/write_en form a one-cycle push strobe with no
  // back-pressure; spi_in is valid in the strobe cycle and held until the next.
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(NUM_BYTES);
  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(NUM_BYTES - 1);

  logic                   sclk_rise;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   mosi_d;
  logic                   ss_s;

  logic [2:0]             bit_cnt;
  logic [BYTE_W-1:0]      shreg;
  logic                   byte_done;
  logic [BYTE_W-1:0]      byte_buf;

  state_t                 state_q;
  state_t                 state_d;
  logic                   load_ok;
  logic                   accept;
  logic                   drop;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (sclk),
    .rise  (sclk_rise)
  );

  // mosi_d re-aligns data with the extra register in the sclk edge path.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mosi_sync <= '0;
      ss_sync   <= '1;
      mosi_d    <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  assign ss_s = ss_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      byte_buf  <= '0;
    end else begin
      byte_done <= 1'b0;
      if (ss_s) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (sclk_rise) begin
        shreg   <= shift_in(shreg, mosi_d);
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          byte_buf  <= shift_in(shreg, mosi_d);
        end
      end
    end
  end

  // frame_clr has priority over a completing byte and suppresses overrun.
  assign accept = byte_done & load_ok & ~network_calc & ~frame_clr;
  assign drop   = byte_done & ~accept & ~frame_clr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (byte_count == LAST_CNT) ? FULL : LOAD;
      end
      LOAD: begin
        if (frame_clr)                               state_d = IDLE;
        else if (accept && byte_count == LAST_CNT)   state_d = FULL;
      end
      FULL: begin
        if (frame_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ok     = 1'b0;
    image_ready = 1'b0;
    state_dbg   = state_q;
    case (state_q)
      IDLE:    load_ok     = 1'b1;
      LOAD:    load_ok     = 1'b1;
      FULL:    image_ready = 1'b1;
      default: load_ok     = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      spi_in     <= '0;
      shift_SPI  <= 1'b0;
      write_en   <= 1'b0;
      byte_count <= '0;
      overrun    <= 1'b0;
    end else begin
      shift_SPI <= accept;
      write_en  <= accept;
      if (accept) spi_in <= byte_buf;

      if (frame_clr)                           byte_count <= '0;
      else if (accept && byte_count != FULL_CNT) byte_count <= byte_count + 1'b1;

      if (frame_clr)  overrun <= 1'b0;
      else if (drop)  overrun <= 1'b1;
    end
  end

`ifdef SPI_PIXEL_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      checksum <= '0;
    end else if (frame_clr) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum ^ byte_buf;
    end
  end
`endif

endmodule

// File: doc/spi_pixel_loader.md
SPI_PIXEL_LOADER -- requirements
Module: spi_pixel_loader

Interface
REQ-001 Parameter NUM_BYTES, default 72, is the number of bytes per image frame (one full pixel buffer).
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops on each SPI input.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  SPI serial clock from the external master, asynchronous to clk.
REQ-006 mosi  input  1  SPI data from the master, MSB first, sampled on sclk rising edge (mode 0).
REQ-007 ss_n  input  1  SPI slave select, active low, asynchronous to clk.
REQ-008 network_calc  input  1  downstream network owns the pixel buffer; loader must not write.
REQ-009 frame_clr  input  1  one-cycle pulse from the controller; consumes the current frame and re-arms loading.
REQ-010 spi_in  output  8  last completed byte, held stable until the next byte completes.
REQ-011 shift_SPI  output  1  one-cycle strobe shifting the pixel buffer.
REQ-012 write_en  output  1  one-cycle strobe selecting spi_in as buffer input; always coincident with shift_SPI.
REQ-013 byte_count  output  7  bytes accepted in the current frame, 0..NUM_BYTES.
REQ-014 image_ready  output  1  level; a complete frame is in the buffer.
REQ-015 overrun  output  1  sticky; a byte arrived while it could not be accepted.

Function
REQ-016 sclk, mosi and ss_n each pass through SYNC_STAGES flops; sclk rising edges are detected by one further register, so each sclk rise yields one single-cycle edge pulse.
REQ-017 On each detected edge with synchronized ss_n low, the synchronized mosi value shifts into an 8-bit shift register from the LSB end, and a 3-bit bit counter increments.
REQ-018 When the bit counter wraps from 7 to 0, the byte is complete; spi_in loads the assembled byte on the following clk edge.
REQ-019 shift_SPI and write_en are high for exactly the one cycle in which spi_in first shows the new byte, and only when the byte is accepted.
REQ-020 End-to-end latency: strobe appears 4 clk cycles after the clk edge that first samples the 8th sclk rise at the sync input; sclk frequency SHALL be at most clk/4.
REQ-021 State machine: IDLE (byte_count 0), LOAD (0 < byte_count < NUM_BYTES), FULL (image_ready high).
REQ-022 IDLE->LOAD on first accepted byte; LOAD->FULL when the NUM_BYTES-th byte is accepted; FULL->IDLE on frame_clr.
REQ-023 A byte is accepted only in IDLE or LOAD with network_calc low; otherwise it is dropped (no strobe, spi_in unchanged) and overrun sets.
REQ-024 byte_count increments by one per accepted byte, saturates at NUM_BYTES, and clears to 0 on FULL->IDLE.
REQ-025 Synchronized ss_n high clears the bit counter and shift register immediately; partial bytes are discarded and byte_count is unaffected.
REQ-026 frame_clr in IDLE or LOAD clears byte_count to 0 and returns to IDLE; frame_clr coincident with byte completion wins and the byte is dropped without setting overrun.
REQ-027 overrun clears only on frame_clr or reset.

Reset
REQ-028 While n_rst is low: state IDLE, spi_in 0x00, shift_SPI 0, write_en 0, byte_count 0, image_ready 0, overrun 0, sync chains at idle levels (sclk 0, ss_n 1, mosi 0), bit counter 0.
REQ-029 Reset asserted mid-byte or mid-frame discards all progress; the first byte after reset starts a new frame.

Configuration
REQ-030 SPI_PIXEL_LOADER_CHECKSUM_EN defined: an extra output checksum[7:0] holds the XOR of all bytes accepted in the current frame, cleared with byte_count; undefined: the port and logic are absent and nothing else changes.

Structure
REQ-031 A shared package holds the state enumerated type (IDLE, LOAD, FULL) and the constants NUM_PIXEL_BYTES = 72 and BYTE_W = 8.
REQ-032 One sub-module, spi_sync_edge, implements a single-bit synchronizer with rising-edge detection; it is instantiated for sclk, with plain synchronizers used for mosi and ss_n.

Verification
REQ-033 Reset, then send byte 0xA5 with ss_n low -> spi_in = 0xA5, single shift_SPI/write_en pulse 4 clk after the 8th sync sample, byte_count = 1.
REQ-034 Send 72 bytes 0x00..0x47 -> exactly 72 strobes, image_ready rises with the 72nd strobe, byte_count = 72, final spi_in = 0x47.
REQ-035 In FULL, send 0xFF -> no strobe, spi_in stays 0x47, overrun = 1; then frame_clr -> IDLE, byte_count 0, overrun 0.
REQ-036 Send 5 bits, raise ss_n, lower ss_n, send 0x3C -> spi_in = 0x3C, exactly one strobe.
REQ-037 Hold network_calc high and send 0x12 -> dropped, overrun = 1; assert n_rst low mid-byte -> all outputs return to their reset values.
REQ-038 With SPI_PIXEL_LOADER_CHECKSUM_EN defined, send 0x0F, 0xF0, 0x33 -> checksum = 0xCC.
